// File: rtl/otter_pkg.sv
// Shared OTTER constants: opcodes, PC source selects, mcause values, PC FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package otter_pkg;

   // RV32I major opcodes (ir[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // funct12 of MRET within the SYSTEM/funct3=0 space
   localparam logic [11:0] F12_MRET = 12'h302;

   // PC next-address mux selects, shared with otter_pc
   localparam logic [2:0] PC_SRC_INC    = 3'd0;
   localparam logic [2:0] PC_SRC_JALR   = 3'd1;
   localparam logic [2:0] PC_SRC_BRANCH = 3'd2;
   localparam logic [2:0] PC_SRC_JAL    = 3'd3;
   localparam logic [2:0] PC_SRC_MTVEC  = 3'd4;
   localparam logic [2:0] PC_SRC_MEPC   = 3'd5;

   // mcause values
   localparam logic [31:0] MCAUSE_INTR    = 32'h8000_000B;
   localparam logic [31:0] MCAUSE_ILLEGAL = 32'h0000_0002;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_WB    = 2'd2,
      ST_TRAP  = 2'd3
   } state_t;

endpackage

// File: rtl/otter_pc_ctrl_if.sv
// Bundle between the PC sequencer and the decoder / comparator / CSR / PC datapath.
// Latency: n/a (wires only).
// Backpressure: imem_valid / dmem_valid stall the sequencer; no other flow control.
// master = sequencer (consumes instruction fields and flags, drives controls)
// slave  = datapath side (drives instruction fields and flags, consumes controls)
interface otter_pc_ctrl_if;
   import otter_pkg::*;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [11:0] funct12;
   logic        br_eq;
   logic        br_lt;
   logic        br_ltu;
   logic        intr;
   logic        mie;
   logic        imem_valid;
   logic        dmem_valid;

   logic        imem_rd;
   logic        ir_load;
   logic        dmem_rd;
   logic        rf_w_en;
   logic        pc_w_en;
   logic [2:0]  pc_src_sel;
   logic        trap_take;
   logic [31:0] trap_cause;
   logic        mret;

   modport master (
      input  opcode, funct3, funct12, br_eq, br_lt, br_ltu, intr, mie,
             imem_valid, dmem_valid,
      output imem_rd, ir_load, dmem_rd, rf_w_en, pc_w_en, pc_src_sel,
             trap_take, trap_cause, mret
   );

   modport slave (
      output opcode, funct3, funct12, br_eq, br_lt, br_ltu, intr, mie,
             imem_valid, dmem_valid,
      input  imem_rd, ir_load, dmem_rd, rf_w_en, pc_w_en, pc_src_sel,
             trap_take, trap_cause, mret
   );

endinterface

// File: rtl/otter_branch_cond.sv
// Maps branch funct3 and comparator flags to taken / illegal-encoding.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_funct3, i_br_eq, i_br_lt, i_br_ltu in; o_taken, o_illegal out.
module otter_branch_cond (
   input  logic [2:0] i_funct3,
   input  logic       i_br_eq,
   input  logic       i_br_lt,
   input  logic       i_br_ltu,
   output logic       o_taken,
   output logic       o_illegal
);

   always_comb begin
      o_taken   = 1'b0;
      o_illegal = 1'b0;
      case (i_funct3)
         3'b000:  o_taken = i_br_eq;     // BEQ
         3'b001:  o_taken = ~i_br_eq;    // BNE
         3'b100:  o_taken = i_br_lt;     // BLT
         3'b101:  o_taken = ~i_br_lt;    // BGE
         3'b110:  o_taken = i_br_ltu;    // BLTU
         3'b111:  o_taken = ~i_br_ltu;   // BGEU
         default: o_illegal = 1'b1;      // 010 / 011 unallocated
      endcase
   end

endmodule

// File: rtl/otter_pc_ctrl.sv
// Multicycle PC sequencer: FETCH -> EXEC [-> WB] [-> TRAP] -> FETCH.
// Latency: 2 cycles per instruction, +1 per load (plus memory stalls), +1 on trap.
// Backpressure: holds in FETCH until imem_valid and in WB until dmem_valid.
// Ports: clk, rst (sync, active-high); bus (otter_pc_ctrl_if.master) carries
// instruction fields, comparator flags, intr/mie, memory valids, and all controls.
module otter_pc_ctrl
   import otter_pkg::*;
#(
   parameter logic [31:0] INTR_CAUSE    = MCAUSE_INTR,
   parameter logic [31:0] ILLEGAL_CAUSE = MCAUSE_ILLEGAL
) (
   input  logic               clk,
   input  logic               rst,
   otter_pc_ctrl_if.master    bus
);

   state_t      r_state;
   logic [31:0] r_cause;

   state_t      w_state_nxt;
   logic        w_cause_ld;
   logic [31:0] w_cause_nxt;

   logic        w_br_taken;
   logic        w_br_illegal;

   // decode of the instruction sitting in IR
   logic        w_legal;
   logic        w_is_load;
   logic [2:0]  w_dec_sel;
   logic        w_dec_rf;
   logic        w_dec_mret;

   // instruction completes this cycle; interrupts are only sampled here
   logic        w_done;

   logic        w_imem_rd;
   logic        w_ir_load;
   logic        w_dmem_rd;
   logic        w_rf_w_en;
   logic        w_pc_w_en;
   logic [2:0]  w_pc_src_sel;
   logic        w_trap_take;
   logic [31:0] w_trap_cause;
   logic        w_mret;

   otter_branch_cond u_branch_cond (
      .i_funct3  (bus.funct3),
      .i_br_eq   (bus.br_eq),
      .i_br_lt   (bus.br_lt),
      .i_br_ltu  (bus.br_ltu),
      .o_taken   (w_br_taken),
      .o_illegal (w_br_illegal)
   );

   always_comb begin
      w_legal    = 1'b1;
      w_is_load  = 1'b0;
      w_dec_sel  = PC_SRC_INC;
      w_dec_rf   = 1'b0;
      w_dec_mret = 1'b0;
      case (bus.opcode)
         OP_LOAD:   w_is_load = 1'b1;
         OP_BRANCH: begin
            w_legal   = ~w_br_illegal;
            w_dec_sel = w_br_taken ? PC_SRC_BRANCH : PC_SRC_INC;
         end
         OP_JAL: begin
            w_dec_sel = PC_SRC_JAL;
            w_dec_rf  = 1'b1;
         end
         OP_JALR: begin
            w_dec_sel = PC_SRC_JALR;
            w_dec_rf  = 1'b1;
         end
         OP_OP, OP_IMM, OP_LUI, OP_AUIPC: w_dec_rf = 1'b1;
         OP_STORE:  ;
         OP_SYSTEM: begin
            if (bus.funct3 != 3'b000) begin
               w_dec_rf = 1'b1;                // CSR access
            end else if (bus.funct12 == F12_MRET) begin
               w_dec_sel  = PC_SRC_MEPC;
               w_dec_mret = 1'b1;
            end else begin
               w_legal = 1'b0;                 // ECALL/EBREAK/WFI etc. unsupported
            end
         end
         default:   w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cause_ld   = 1'b0;
      w_cause_nxt  = ILLEGAL_CAUSE;
      w_done       = 1'b0;
      w_imem_rd    = 1'b0;
      w_ir_load    = 1'b0;
      w_dmem_rd    = 1'b0;
      w_rf_w_en    = 1'b0;
      w_pc_w_en    = 1'b0;
      w_pc_src_sel = PC_SRC_INC;
      w_trap_take  = 1'b0;
      w_trap_cause = '0;
      w_mret       = 1'b0;

      case (r_state)
         ST_FETCH: begin
            w_imem_rd = 1'b1;
            if (bus.imem_valid) begin
               w_ir_load   = 1'b1;
               w_state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!w_legal) begin
               // PC left on the faulting instruction so mepc captures it
               w_cause_ld  = 1'b1;
               w_cause_nxt = ILLEGAL_CAUSE;
               w_state_nxt = ST_TRAP;
            end else if (w_is_load) begin
               w_dmem_rd   = 1'b1;
               w_state_nxt = ST_WB;
            end else begin
               w_pc_w_en    = 1'b1;
               w_pc_src_sel = w_dec_sel;
               w_rf_w_en    = w_dec_rf;
               w_mret       = w_dec_mret;
               w_done       = 1'b1;
            end
         end
         ST_WB: begin
            w_dmem_rd = 1'b1;
            if (bus.dmem_valid) begin
               w_rf_w_en = 1'b1;
               w_pc_w_en = 1'b1;
               w_done    = 1'b1;
            end
         end
         ST_TRAP: begin
            w_pc_w_en    = 1'b1;
            w_pc_src_sel = PC_SRC_MTVEC;
            w_trap_take  = 1'b1;
            w_trap_cause = r_cause;
            w_state_nxt  = ST_FETCH;
         end
         default: w_state_nxt = ST_FETCH;
      endcase

      // mie is the pre-MRET value, so an interrupt enabled by MRET waits one instruction
      if (w_done) begin
         if (bus.intr && bus.mie) begin
            w_cause_ld  = 1'b1;
            w_cause_nxt = INTR_CAUSE;
            w_state_nxt = ST_TRAP;
         end else begin
            w_state_nxt = ST_FETCH;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FETCH;
         r_cause <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_cause_ld) begin
            r_cause <= w_cause_nxt;
         end
      end
   end

   // all controls forced low during reset so no stale request escapes
   assign bus.imem_rd    = w_imem_rd & ~rst;
   assign bus.ir_load    = w_ir_load & ~rst;
   assign bus.dmem_rd    = w_dmem_rd & ~rst;
   assign bus.rf_w_en    = w_rf_w_en & ~rst;
   assign bus.pc_w_en    = w_pc_w_en & ~rst;
   assign bus.pc_src_sel = rst ? 3'd0 : w_pc_src_sel;
   assign bus.trap_take  = w_trap_take & ~rst;
   assign bus.trap_cause = rst ? 32'd0 : w_trap_cause;
   assign bus.mret       = w_mret & ~rst;

endmodule

// File: tb/tb_otter_pc_ctrl.sv
// Self-checking bench for otter_pc_ctrl: directed literal checks, then random stimulus.
// Latency: n/a.
// Backpressure: randomised imem_valid / dmem_valid.
module tb_otter_pc_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   otter_pc_ctrl_if bus ();

   otter_pc_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] rs1, rs2;

   // ---------------------------------------------------------------- model
   localparam int M_FETCH = 0, M_EXEC = 1, M_WB = 2, M_TRAP = 3;
   localparam int K_ILL = 0, K_LOAD = 1, K_BR = 2, K_JAL = 3, K_JALR = 4,
                  K_ALU = 5, K_STORE = 6, K_CSR = 7, K_MRET = 8;

   int          m_phase = M_FETCH;
   int          m_next;
   logic [31:0] m_cause = '0;
   bit          m_known = 1'b0;
   bit          m_done;
   int          m_kind;

   logic        e_imem, e_irl, e_dmem, e_rf, e_pcw, e_tt, e_mret;
   logic [2:0]  e_sel;
   logic [31:0] e_cause;
   logic [41:0] e_vec, a_vec;

   function automatic int classify(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [11:0] f12);
      case (op)
         7'b0000011: return K_LOAD;
         7'b1100011: return (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_BR;
         7'b1101111: return K_JAL;
         7'b1100111: return K_JALR;
         7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return K_ALU;
         7'b0100011: return K_STORE;
         7'b1110011: begin
            if (f3 != 3'd0) return K_CSR;
            return (f12 == 12'h302) ? K_MRET : K_ILL;
         end
         default: return K_ILL;
      endcase
   endfunction

   // branch outcome from the operand values themselves
   function automatic bit br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) <  $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a <  b;
         default: return a >= b;
      endcase
   endfunction

   always @(negedge clk) begin
      {e_imem, e_irl, e_dmem, e_rf, e_pcw, e_tt, e_mret} = '0;
      e_sel   = 3'd0;
      e_cause = 32'd0;
      m_done  = 1'b0;
      m_next  = m_phase;
      if (rst) begin
         m_next  = M_FETCH;
         m_cause = 32'd0;
         m_known = 1'b1;
      end else begin
         case (m_phase)
            M_FETCH: begin
               e_imem = 1'b1;
               if (bus.imem_valid) begin
                  e_irl  = 1'b1;
                  m_next = M_EXEC;
               end
            end
            M_EXEC: begin
               m_kind = classify(bus.opcode, bus.funct3, bus.funct12);
               if (m_kind == K_ILL) begin
                  m_cause = 32'd2;
                  m_next  = M_TRAP;
               end else if (m_kind == K_LOAD) begin
                  e_dmem = 1'b1;
                  m_next = M_WB;
               end else begin
                  e_pcw  = 1'b1;
                  m_done = 1'b1;
                  e_rf   = (m_kind == K_JAL || m_kind == K_JALR || m_kind == K_ALU || m_kind == K_CSR);
                  e_mret = (m_kind == K_MRET);
                  case (m_kind)
                     K_JAL:   e_sel = 3'd3;
                     K_JALR:  e_sel = 3'd1;
                     K_MRET:  e_sel = 3'd5;
                     K_BR:    e_sel = br_taken(bus.funct3, rs1, rs2) ? 3'd2 : 3'd0;
                     default: e_sel = 3'd0;
                  endcase
               end
            end
            M_WB: begin
               e_dmem = 1'b1;
               if (bus.dmem_valid) begin
                  e_rf   = 1'b1;
                  e_pcw  = 1'b1;
                  m_done = 1'b1;
               end
            end
            default: begin
               e_pcw   = 1'b1;
               e_sel   = 3'd4;
               e_tt    = 1'b1;
               e_cause = m_cause;
               m_next  = M_FETCH;
            end
         endcase
         if (m_done) begin
            if (bus.intr && bus.mie) begin
               m_cause = 32'h8000_000B;
               m_next  = M_TRAP;
            end else begin
               m_next = M_FETCH;
            end
         end
      end
      if (m_known) begin
         e_vec = {e_imem, e_irl, e_dmem, e_rf, e_pcw, e_sel, e_tt, e_mret, e_cause};
         a_vec = {bus.imem_rd, bus.ir_load, bus.dmem_rd, bus.rf_w_en, bus.pc_w_en,
                  bus.pc_src_sel, bus.trap_take, bus.mret, bus.trap_cause};
         checks++;
         if (a_vec !== e_vec) begin
            errors++;
            $display("FAIL model_cycle t=%0t: got %h expected %h", $time, a_vec, e_vec);
         end
      end
      m_phase = m_next;
   end

   // ---------------------------------------------------------------- driver
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rs(input logic [31:0] a, input logic [31:0] b);
      rs1 = a;
      rs2 = b;
      bus.br_eq  = (a == b);
      bus.br_lt  = ($signed(a) < $signed(b));
      bus.br_ltu = (a < b);
   endtask

   // called while in FETCH; returns one cycle later in EXEC
   task automatic do_fetch(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] f12);
      bus.opcode     = op;
      bus.funct3     = f3;
      bus.funct12    = f12;
      bus.imem_valid = 1'b1;
      cyc();
      bus.imem_valid = 1'b0;
   endtask

   logic [6:0] rnd_ops [12];

   initial begin
      rnd_ops = '{7'b0000011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110011, 7'b0010011,
                  7'b0110111, 7'b0010111, 7'b0100011, 7'b1110011, 7'b0000000, 7'b1111111};
      rst = 1'b1;
      bus.opcode = '0; bus.funct3 = '0; bus.funct12 = '0;
      bus.intr = 1'b0; bus.mie = 1'b0;
      bus.imem_valid = 1'b0; bus.dmem_valid = 1'b0;
      set_rs(32'd0, 32'd0);

      cyc(); #2;
      chk("reset_pc_w_en", 32'(bus.pc_w_en), 32'd0);
      chk("reset_imem_rd", 32'(bus.imem_rd), 32'd0);

      // enter a WB stall, then reset for two cycles
      cyc(); rst = 1'b0;
      bus.opcode = 7'b0000011; bus.funct3 = 3'd2; bus.imem_valid = 1'b1; #2;
      chk("fetch_imem_rd", 32'(bus.imem_rd), 32'd1);
      chk("fetch_ir_load", 32'(bus.ir_load), 32'd1);
      cyc(); bus.imem_valid = 1'b0; #2;
      chk("lw_exec_dmem_rd", 32'(bus.dmem_rd), 32'd1);
      chk("lw_exec_pc_w_en", 32'(bus.pc_w_en), 32'd0);
      cyc(); rst = 1'b1; #2;
      chk("rst_in_wb_dmem_rd", 32'(bus.dmem_rd), 32'd0);
      chk("rst_in_wb_pc_w_en", 32'(bus.pc_w_en), 32'd0);
      cyc(); #2;
      chk("rst_in_wb2_pc_w_en", 32'(bus.pc_w_en), 32'd0);
      cyc(); rst = 1'b0;
      bus.opcode = 7'b0010011; bus.funct3 = 3'd0; bus.imem_valid = 1'b1; #2;
      chk("post_reset_imem_rd", 32'(bus.imem_rd), 32'd1);

      // ADDI
      cyc(); bus.imem_valid = 1'b0; #2;
      chk("addi_pc_w_en", 32'(bus.pc_w_en), 32'd1);
      chk("addi_sel", 32'(bus.pc_src_sel), 32'd0);
      chk("addi_rf_w_en", 32'(bus.rf_w_en), 32'd1);
      cyc(); #2;
      chk("addi_back_fetch", 32'(bus.imem_rd), 32'd1);

      // branches
      set_rs(32'd5, 32'd7);
      do_fetch(7'b1100011, 3'd1, 12'd0); #2;
      chk("bne_taken_sel", 32'(bus.pc_src_sel), 32'd2);
      cyc();
      set_rs(32'd9, 32'd9);
      do_fetch(7'b1100011, 3'd1, 12'd0); #2;
      chk("bne_not_taken_sel", 32'(bus.pc_src_sel), 32'd0);
      cyc();
      set_rs(32'd1, 32'hFFFF_FFFF);
      do_fetch(7'b1100011, 3'd6, 12'd0); #2;
      chk("bltu_taken_sel", 32'(bus.pc_src_sel), 32'd2);
      cyc();
      do_fetch(7'b1100011, 3'd2, 12'd0); #2;
      chk("br_f3_010_pc_w_en", 32'(bus.pc_w_en), 32'd0);
      cyc(); #2;
      chk("br_f3_010_trap_take", 32'(bus.trap_take), 32'd1);
      chk("br_f3_010_cause", bus.trap_cause, 32'd2);
      chk("br_f3_010_sel", 32'(bus.pc_src_sel), 32'd4);
      cyc();

      // LW with dmem_valid on the third WB cycle
      do_fetch(7'b0000011, 3'd2, 12'd0); #2;
      chk("lw2_exec_dmem_rd", 32'(bus.dmem_rd), 32'd1);
      for (int i = 0; i < 2; i++) begin
         cyc(); #2;
         chk("lw2_stall_dmem_rd", 32'(bus.dmem_rd), 32'd1);
         chk("lw2_stall_pc_w_en", 32'(bus.pc_w_en), 32'd0);
         chk("lw2_stall_rf_w_en", 32'(bus.rf_w_en), 32'd0);
      end
      cyc(); bus.dmem_valid = 1'b1; #2;
      chk("lw2_done_dmem_rd", 32'(bus.dmem_rd), 32'd1);
      chk("lw2_done_rf_w_en", 32'(bus.rf_w_en), 32'd1);
      chk("lw2_done_pc_w_en", 32'(bus.pc_w_en), 32'd1);
      cyc(); bus.dmem_valid = 1'b0;

      // JAL with interrupt pending and enabled
      bus.intr = 1'b1; bus.mie = 1'b1;
      do_fetch(7'b1101111, 3'd0, 12'd0); #2;
      chk("jal_intr_sel", 32'(bus.pc_src_sel), 32'd3);
      chk("jal_intr_rf_w_en", 32'(bus.rf_w_en), 32'd1);
      cyc(); #2;
      chk("intr_trap_take", 32'(bus.trap_take), 32'd1);
      chk("intr_trap_sel", 32'(bus.pc_src_sel), 32'd4);
      chk("intr_trap_cause", bus.trap_cause, 32'h8000_000B);
      cyc();
      bus.mie = 1'b0;
      do_fetch(7'b1101111, 3'd0, 12'd0); #2;
      chk("jal_nomie_sel", 32'(bus.pc_src_sel), 32'd3);
      cyc(); #2;
      chk("jal_nomie_no_trap", 32'(bus.trap_take), 32'd0);
      chk("jal_nomie_fetch", 32'(bus.imem_rd), 32'd1);

      // MRET
      bus.intr = 1'b0;
      do_fetch(7'b1110011, 3'd0, 12'h302); #2;
      chk("mret_sel", 32'(bus.pc_src_sel), 32'd5);
      chk("mret_flag", 32'(bus.mret), 32'd1);
      cyc();

      // illegal opcode with simultaneous interrupt
      bus.intr = 1'b1; bus.mie = 1'b1;
      do_fetch(7'b0000000, 3'd0, 12'd0); #2;
      chk("ill_pc_w_en", 32'(bus.pc_w_en), 32'd0);
      cyc(); #2;
      chk("ill_trap_take", 32'(bus.trap_take), 32'd1);
      chk("ill_trap_cause", bus.trap_cause, 32'd2);
      cyc();

      // random stimulus against the model
      for (int i = 0; i < 4000; i++) begin
         rst            = ($urandom_range(0, 59) == 0);
         bus.opcode     = rnd_ops[$urandom_range(0, 11)];
         bus.funct3     = 3'($urandom_range(0, 7));
         bus.funct12    = ($urandom_range(0, 1) == 1) ? 12'h302 : 12'($urandom);
         bus.imem_valid = ($urandom_range(0, 1) == 1);
         bus.dmem_valid = ($urandom_range(0, 2) == 0);
         bus.intr       = ($urandom_range(0, 2) == 0);
         bus.mie        = ($urandom_range(0, 1) == 1);
         begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            set_rs(a, b);
         end
         cyc();
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/otter_pc_ctrl.md
Name: otter_pc_ctrl

Overview:
Multicycle sequencing FSM for the OTTER core's program counter. It paces fetch, execute, load writeback and trap entry. Each cycle it drives the PC's write enable and 3-bit next-address source select, and resolves branch conditions, JAL/JALR, MRET, illegal opcodes and external interrupts. It sits between the instruction register/decoder, the branch comparator, the CSR file and the PC register.

Parameters:
INTR_CAUSE, 32'h8000_000B, mcause value for machine external interrupt
ILLEGAL_CAUSE, 32'h0000_0002, mcause value for illegal instruction

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
opcode  in  7  ir[6:0]
funct3  in  3  ir[14:12]
funct12  in  12  ir[31:20], used for MRET detection
br_eq  in  1  rs1 == rs2
br_lt  in  1  signed rs1 < rs2
br_ltu  in  1  unsigned rs1 < rs2
intr  in  1  level external interrupt request
mie  in  1  mstatus.MIE from CSR file
imem_valid  in  1  instruction fetch data valid
dmem_valid  in  1  load data valid
imem_rd  out  1  fetch request
ir_load  out  1  latch instruction register
dmem_rd  out  1  load request
rf_w_en  out  1  register file write
pc_w_en  out  1  PC write enable
pc_src_sel  out  3  0 inc, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc
trap_take  out  1  CSR: mepc<=PC, mcause<=trap_cause, MIE<=0
trap_cause  out  32  cause for trap_take
mret  out  1  CSR: restore MIE

Behaviour:
- Synchronous reset and one clock, as already decided. Reset is synchronous and active-high. It puts the FSM in FETCH and clears the pending-cause register.
- While rst=1, every output is 0, and pc_src_sel and trap_cause are 0.
- The only state is the 2-bit FSM plus a cause register. Outputs are combinational from state and inputs.
- States: FETCH=0, EXEC=1, WB=2, TRAP=3. Code 3 is the last encoding. There are no unreachable codes.
- FETCH:
  - imem_rd=1. Hold until imem_valid.
  - On imem_valid: ir_load=1, go to EXEC. The PC is not written.
- EXEC (the decode below is one-cycle and drives pc_w_en=1 unless stated otherwise):
  - LOAD 0000011: dmem_rd=1, pc_w_en=0, go to WB.
  - BRANCH 1100011:
    - funct3 000 taken if eq; 001 if !eq; 100 if lt; 101 if !lt; 110 if ltu; 111 if !ltu.
    - Taken: sel=2. Not taken: sel=0.
    - funct3 010 or 011 is illegal.
  - JAL 1101111: sel=3, rf_w_en=1.
  - JALR 1100111: sel=1, rf_w_en=1.
  - OP, OP-IMM, LUI, AUIPC: sel=0, rf_w_en=1.
  - STORE: sel=0.
  - SYSTEM 1110011:
    - funct3!=0 (CSR op): sel=0, rf_w_en=1.
    - funct3=0 and funct12=12'h302: sel=5, mret=1.
    - Any other funct3=0 encoding is illegal.
  - Illegal (any other opcode or encoding): pc_w_en=0, cause<=ILLEGAL_CAUSE, go to TRAP. The PC stays on the faulting instruction, so mepc holds the faulting PC.
  - Legal instruction with intr&mie=1 this cycle: cause<=INTR_CAUSE, go to TRAP. Otherwise go to FETCH.
  - An illegal instruction wins over a simultaneous interrupt.
- WB:
  - Hold with dmem_rd=1 until dmem_valid.
  - On dmem_valid: rf_w_en=1, pc_w_en=1, sel=0, then the same interrupt check as EXEC.
- TRAP (exactly one cycle): pc_w_en=1, sel=4, trap_take=1, trap_cause=cause. The PC already holds the return address at this point. Go to FETCH.
- MRET and an interrupt in the same EXEC cycle: mret=1 is asserted first and the interrupt is checked using the incoming mie (pre-restore). A newly enabled interrupt is taken after the next instruction.
- Interrupts are sampled only at instruction completion (the last cycle of EXEC or WB). intr asserted during FETCH or a WB stall has no effect until then.
- Reset mid-stall (FETCH or WB): the next cycle is FETCH and any outstanding request is dropped.
- trap_cause reads 0 outside TRAP.

Decomposition:
- Shared package otter_pkg holds:
  - opcode localparams (OP_LOAD, OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM, ...);
  - PC source codes PC_SRC_INC=0 through PC_SRC_MEPC=5, also used by otter_pc;
  - mcause constants;
  - FSM state encodings.
- One natural sub-module: otter_branch_cond, a combinational mapping of funct3 plus flags to taken/illegal.

Test Plan:
- Reset held 2 cycles mid-WB stall, then released with imem_valid=1 -> first cycle imem_rd=1, FETCH; no pc_w_en during reset.
- ADDI, opcode 0010011, imem_valid at cycle 1 -> EXEC at cycle 2 with pc_w_en=1, sel=0, rf_w_en=1; back in FETCH at cycle 3.
- BNE (funct3 001) with br_eq=0 -> sel=2. Repeat with br_eq=1 -> sel=0. BLTU with br_ltu=1 -> sel=2. funct3 010 -> trap_take, trap_cause=2.
- LW with dmem_valid delayed 3 cycles -> dmem_rd held 4 cycles; rf_w_en and pc_w_en sel=0 only on the dmem_valid cycle.
- intr=1, mie=1 during JAL -> EXEC sel=3, next cycle TRAP sel=4, trap_take=1, trap_cause=32'h8000000B. With mie=0 -> no trap.
- MRET (funct12=0x302) -> sel=5, mret=1. Illegal opcode 0000000 with intr&mie=1 -> pc_w_en=0 in EXEC, then TRAP with cause 2.
